spi_ram_bridge: RTL

SPI-slave front end that loads and reads the on-chip RAM32 macro (32 words × 32 bits, byte write enables) from an external host. It sits directly upstream of the RAM32 instance and drives its EN0/A0/WE0/Di0 pins. It replaces parallel byte access through ui_in/uio_in with a 4-wire serial protocol that uses auto-incrementing byte addresses.

---
 rtl/spi_ram_pkg.sv | 19 +
 rtl/spi_ram_bridge_if.sv | 27 ++
 rtl/spi_ram_sync.sv | 33 +++
 rtl/spi_ram_bridge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared geometry, command bit and state encoding for the SPI RAM bridge
package spi_ram_pkg;

    localparam int ADDR_W        = 7;
    localparam int WORD_A_W      = 5;
    localparam int LANES         = 4;
    localparam int CMD_WRITE_BIT = 7;
    localparam int SCK_MIN_DIV   = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR_DATA  = 3'd2,
        RD_FETCH = 3'd3,
        RD_DATA  = 3'd4,
        IGNORE   = 3'd5
    } state_t;

endpackage

// File: rtl/spi_ram_bridge_if.sv
// rtl/spi_ram_bridge_if.sv - RAM32 port bundle between the bridge (master) and the RAM macro (slave)
interface spi_ram_bridge_if;
    import spi_ram_pkg::*;

    logic                   ram_en;
    logic [WORD_A_W-1:0]    ram_a;
    logic [LANES-1:0]       ram_we;
    logic [8*LANES-1:0]     ram_di;
    logic [8*LANES-1:0]     ram_do;

    modport master (
        output ram_en,
        output ram_a,
        output ram_we,
        output ram_di,
        input  ram_do
    );

    modport slave (
        input  ram_en,
        input  ram_a,
        input  ram_we,
        input  ram_di,
        output ram_do
    );

endinterface

// File: rtl/spi_ram_sync.sv
// rtl/spi_ram_sync.sv - 2-FF synchronizer with rise/fall pulses derived from the synchronized value
module spi_ram_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Two flops for metastability, a third to remember the last synchronized value.
    // Reset to 0 so that a pin held low through reset never produces a fall pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_ram_bridge.sv
// rtl/spi_ram_bridge.sv - SPI mode-0 slave that writes/reads RAM32 with auto-incrementing byte addresses (optional reads: SPI_RAM_READ_EN)
module spi_ram_bridge
    import spi_ram_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_sck,
    input  logic                spi_cs_n,
    input  logic                spi_mosi,
    output logic                spi_miso,
    spi_ram_bridge_if.master    ram,
    output logic                busy
);

    logic sck_unused_level;
    logic sck_rise;
    logic sck_fall;
    logic cs_s;
    logic cs_unused_rise;
    logic cs_fall;
    logic mosi_s;
    logic mosi_unused_rise;
    logic mosi_unused_fall;

    spi_ram_sync u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_sck),
        .dout  (sck_unused_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_ram_sync u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs_n),
        .dout  (cs_s),
        .rise  (cs_unused_rise),
        .fall  (cs_fall)
    );

    spi_ram_sync u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_mosi),
        .dout  (mosi_s),
        .rise  (mosi_unused_rise),
        .fall  (mosi_unused_fall)
    );

    state_t                 state, state_n;
    logic [2:0]             cnt, cnt_n;
    logic [7:0]             rx, rx_n;
    logic [ADDR_W-1:0]      addr, addr_n;
    logic                   en_q, en_n;
    logic [WORD_A_W-1:0]    a_q, a_n;
    logic [LANES-1:0]       we_q, we_n;
    logic [8*LANES-1:0]     di_q, di_n;
    logic [7:0]             rx_shift;
    logic                   byte_done;

`ifdef SPI_RAM_READ_EN
    logic [7:0]             tx, tx_n;
    logic                   ph, ph_n;
    logic                   skip, skip_n;
`else
    logic                   unused_ram_do;
    assign unused_ram_do = ^ram.ram_do;
`endif

    assign rx_shift  = {rx[6:0], mosi_s};
    assign byte_done = sck_rise && (cnt == 3'd7);

    // State and datapath registers; RAM pins are registered so each access is a clean one-clk pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            rx    <= 8'd0;
            addr  <= '0;
            en_q  <= 1'b0;
            a_q   <= '0;
            we_q  <= '0;
            di_q  <= '0;
`ifdef SPI_RAM_READ_EN
            tx    <= 8'd0;
            ph    <= 1'b0;
            skip  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rx    <= rx_n;
            addr  <= addr_n;
            en_q  <= en_n;
            a_q   <= a_n;
            we_q  <= we_n;
            di_q  <= di_n;
`ifdef SPI_RAM_READ_EN
            tx    <= tx_n;
            ph    <= ph_n;
            skip  <= skip_n;
`endif
        end
    end

    // Next-state and next-RAM-cycle logic; a high CS overrides everything, including a byte completing.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rx_n    = rx;
        addr_n  = addr;
        en_n    = 1'b0;
        a_n     = a_q;
        we_n    = '0;
        di_n    = '0;
`ifdef SPI_RAM_READ_EN
        tx_n    = tx;
        ph_n    = ph;
        skip_n  = skip;
`endif
        if (state != IDLE && cs_s) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
`ifdef SPI_RAM_READ_EN
            ph_n    = 1'b0;
            skip_n  = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Only a real high-to-low CS edge starts a frame.
                    if (cs_fall) begin
                        state_n = CMD;
                        cnt_n   = 3'd0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        rx_n  = rx_shift;
                        cnt_n = cnt + 3'd1;
                    end
                    if (byte_done) begin
                        addr_n = rx_shift[ADDR_W-1:0];
                        if (rx_shift[CMD_WRITE_BIT]) begin
                            state_n = WR_DATA;
                        end else begin
`ifdef SPI_RAM_READ_EN
                            state_n = RD_FETCH;
                            en_n    = 1'b1;
                            a_n     = rx_shift[ADDR_W-1:2];
                            ph_n    = 1'b0;
`else
                            state_n = IGNORE;
`endif
                        end
                    end
                end
                WR_DATA: begin
                    if (sck_rise) begin
                        rx_n  = rx_shift;
                        cnt_n = cnt + 3'd1;
                    end
                    if (byte_done) begin
                        en_n   = 1'b1;
                        a_n    = addr[ADDR_W-1:2];
                        we_n   = {{(LANES-1){1'b0}}, 1'b1} << addr[1:0];
                        di_n   = {LANES{rx_shift}};
                        addr_n = addr + 7'd1;
                    end
                end
`ifdef SPI_RAM_READ_EN
                RD_FETCH: begin
                    // Phase 0 is the enable cycle; phase 1 sees ram_do and captures the lane.
                    if (!ph) begin
                        ph_n = 1'b1;
                    end else begin
                        ph_n    = 1'b0;
                        tx_n    = ram.ram_do[{addr[1:0], 3'b000} +: 8];
                        skip_n  = 1'b1;
                        addr_n  = addr + 7'd1;
                        state_n = RD_DATA;
                    end
                end
                RD_DATA: begin
                    // The fall right after a load already presents bit 7, so it does not shift.
                    if (sck_fall) begin
                        if (skip) begin
                            skip_n = 1'b0;
                        end else begin
                            tx_n = {tx[6:0], 1'b0};
                        end
                    end
                    if (sck_rise) begin
                        cnt_n = cnt + 3'd1;
                    end
                    if (byte_done) begin
                        state_n = RD_FETCH;
                        en_n    = 1'b1;
                        a_n     = addr[ADDR_W-1:2];
                        ph_n    = 1'b0;
                    end
                end
`endif
                IGNORE: begin
                    state_n = IGNORE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign ram.ram_en = en_q;
    assign ram.ram_a  = a_q;
    assign ram.ram_we = we_q;
    assign ram.ram_di = di_q;
    assign busy       = (state != IDLE);

`ifdef SPI_RAM_READ_EN
    assign spi_miso = (state == RD_FETCH || state == RD_DATA) ? tx[7] : 1'b0;
`else
    assign spi_miso = 1'b0;
`endif

endmodule
